// File: rtl/run_det_ctrl_if.sv
// Control, configuration, status and serial bit-stream signals of the run-of-ones detector.
// The controller connects through the slave modport; the driving side connects through master.
interface run_det_ctrl_if #(
  parameter int RUN_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [RUN_W-1:0] cfg_run;
  logic [CNT_W-1:0] cfg_target;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             busy;
  logic             det;
  logic [CNT_W-1:0] det_cnt;
  logic             done;
  logic             err;

  modport slave (
    input  start, abort, cfg_run, cfg_target, in_valid, in_bit,
    output in_ready, busy, det, det_cnt, done, err
  );

  modport master (
    output start, abort, cfg_run, cfg_target, in_valid, in_bit,
    input  in_ready, busy, det, det_cnt, done, err
  );
endinterface

// File: rtl/run_det_ctrl.sv
// Sequencing controller for a serial run-of-ones detector with a detection target count.
// Define RUN_DET_OVERLAP_EN for overlapping detection (run counter saturates after a hit).
module run_det_ctrl #(
  parameter int RUN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  run_det_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
  logic [RUN_W-1:0] cfg_run_q, cfg_run_d;
  logic [CNT_W-1:0] cfg_tgt_q, cfg_tgt_d;
  logic             det_q, det_d;
  logic             err_q, err_d;

  logic             cfg_ok;
  logic             accept;
  logic [RUN_W:0]   run_inc;
  logic [CNT_W-1:0] det_inc;
  logic             hit;
  logic [RUN_W-1:0] run_after_hit;

  assign cfg_ok  = (|bus.cfg_run) & (|bus.cfg_target);
  assign accept  = bus.in_valid & (state_q == RUN);
  assign run_inc = {1'b0, run_cnt_q} + {{RUN_W{1'b0}}, 1'b1};
  assign det_inc = det_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef RUN_DET_OVERLAP_EN
  // Counter sits at the run length after a hit, so each further 1 also hits.
  assign hit           = (run_inc >= {1'b0, cfg_run_q});
  assign run_after_hit = cfg_run_q;
`else
  assign hit           = (run_inc == {1'b0, cfg_run_q});
  assign run_after_hit = '0;
`endif

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    det_cnt_d = det_cnt_q;
    cfg_run_d = cfg_run_q;
    cfg_tgt_d = cfg_tgt_q;
    det_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.abort) begin
          if (state_q == DONE) begin
            state_d   = IDLE;
            run_cnt_d = '0;
          end
        end else if (bus.start) begin
          if (cfg_ok) begin
            cfg_run_d = bus.cfg_run;
            cfg_tgt_d = bus.cfg_target;
            run_cnt_d = '0;
            det_cnt_d = '0;
            state_d   = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end else if (accept) begin
          if (!bus.in_bit) begin
            run_cnt_d = '0;
          end else if (hit) begin
            det_d     = 1'b1;
            det_cnt_d = det_inc;
            run_cnt_d = run_after_hit;
            if (det_inc == cfg_tgt_q) begin
              state_d = DONE;
            end
          end else begin
            run_cnt_d = run_inc[RUN_W-1:0];
          end
        end
      end

      default: begin
        state_d   = IDLE;
        run_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
      det_cnt_q <= '0;
      det_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      det_cnt_q <= det_cnt_d;
      det_q     <= det_d;
      err_q     <= err_d;
    end
  end

  // Config is only meaningful after an accepted start, so it carries no reset.
  always_ff @(posedge clk) begin
    cfg_run_q <= cfg_run_d;
    cfg_tgt_q <= cfg_tgt_d;
  end

  assign bus.in_ready = (state_q == RUN);
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.det      = det_q;
  assign bus.det_cnt  = det_cnt_q;
  assign bus.err      = err_q;

endmodule
